seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed 7-segment driver for N digits. Converts an unsigned binary magnitude to BCD with a sequential shift-add-3 (double-dabble) engine, adds sign, per-digit decimal points, leading-zero blanking and overflow indication, and time-multiplexes the digits.
- Sits between a measurement block (e.g. temperature readout) and the board's common-select/segment pins.

Parameters:
- DIGITS, 6: number of digit positions (2..8).
- BIN_W, 20: width of the binary input magnitude.
- SCAN_DIV, 50000: clk cycles per digit dwell.
- SEL_ACTIVE_LOW, 1: 1 means the selected digit's dis_sel bit is 0.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment or dp is 0.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- din  input  BIN_W  unsigned magnitude to display.
- din_neg  input  1  value is negative; sampled with din.
- dp_mask  input  DIGITS  decimal point enables, bit i = digit i (0 = rightmost); sampled with din.
- din_valid  input  1  load request; single-cycle strobe.
- blank_en  input  1  enables leading-zero blanking; live (not sampled).
- busy  output  1  conversion in progress; new loads are ignored.
- ovf  output  1  last committed value did not fit.
- dis_sel  output  DIGITS  one-hot digit select.
- dis_seg  output  8  {dp, g, f, e, d, c, b, a}.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: busy=0, ovf=0, scan index=0, dis_sel selects digit 0, dis_seg = all segments off.
  - Internal state: display BCD cleared to 0, sign=0, dp register=0, FSM=IDLE.
  - Reset asserted mid-conversion aborts the conversion; nothing is committed.
- FSM states IDLE, CONV, LOAD.
  - IDLE: din_valid=1 captures din, din_neg and dp_mask, clears the BCD shift register, then goes to CONV with busy=1 on the next cycle.
  - CONV: exactly BIN_W cycles. Each cycle:
    - add 3 to every BCD nibble that is at least 5;
    - shift {bcd, bin} left by 1;
    - if the bit leaving the top nibble is 1, set the sticky overflow flag.
  - LOAD: one cycle, then IDLE with busy=0.
  - Total latency from din_valid to the updated display register is BIN_W+2 cycles.
  - din_valid while busy=1 is dropped, with no queueing.
- Overflow at LOAD:
  - Positive value: overflow if the sticky flag is set.
  - Negative value: overflow if the sticky flag is set or the top nibble is nonzero, because a digit is reserved for the sign.
  - On overflow, ovf=1 and every digit shows a dash with dp off. Otherwise ovf=0.
  - ovf holds until the next LOAD.
- LOAD commits the BCD digits, sign and dp register atomically. The display never shows a partial conversion.
- Scan:
  - The dwell counter runs 0..SCAN_DIV-1.
  - At the terminal count the index increments, wrapping from DIGITS-1 to 0.
  - dis_sel and dis_seg are registered from the same index on the same edge. The select and its segment data are never misaligned.
- Blanking: digit i is blank (all off, dp off) only if all of these hold:
  - blank_en=1;
  - i>0;
  - digits i..DIGITS-1 are all 0;
  - no dp bit is set at index i or above.
  - Digit 0 is never blanked.
- Sign:
  - If negative, a dash is shown in the lowest-index blank position above the most significant shown digit.
  - With blank_en=0, the dash is shown on digit DIGITS-1, which is guaranteed 0 by the overflow rule.
  - Negative zero displays as "0" with no dash.
- Segment codes in active-low form, g..a: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, dash 0111111, blank 1111111.
- dp is lit when the digit's dp bit is set and the digit is not blank.
- With SEG_ACTIVE_LOW=0 the whole byte is inverted. SEL_ACTIVE_LOW likewise inverts dis_sel.

Test Plan:
- Reset then idle, defaults (DIGITS=6, SEL/SEG low): dis_sel=6'b111110 and dis_seg=8'hFF for one cycle; thereafter digit 0 shows 8'hC0 and digits 1-5 show 8'hFF with blank_en=1.
- din=12345, dp_mask=0, blank_en=1, pulse din_valid: busy high for exactly 21 cycles. Digits 0..4 show C0-coded 5,4,3,2,1 (8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9); digit 5 shows 8'hFF; ovf=0.
- din=25, din_neg=1, dp_mask=6'b000010: digit0=8'h92, digit1=8'h24 (2 with dp), digit2=8'hBF (dash), digits 3-5 blank.
- din=999999: ovf=0, six 9s shown. Then din=1000000: ovf=1, all digits 8'hBF. Then din=100000 with din_neg=1: ovf=1.
- din_valid pulsed again 5 cycles after the first load: second request ignored, first value displayed. Also assert rst at CONV cycle 10: previous display retained as cleared 0, busy=0.
- SCAN_DIV=4: dis_sel advances every 4 cycles through all 6 one-hot codes and wraps from digit 5 to digit 0; segment data changes on the same edge as dis_sel.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed N-digit 7-segment driver: sequential double-dabble binary-to-BCD
// conversion, sign/dp/leading-zero blanking and overflow dashes, digit scanning.
module seg_scan_ctrl #(
  parameter int DIGITS         = 6,
  parameter int BIN_W          = 20,
  parameter int SCAN_DIV       = 50000,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BIN_W-1:0]  din,
  input  logic              din_neg,
  input  logic [DIGITS-1:0] dp_mask,
  input  logic              din_valid,
  input  logic              blank_en,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] dis_sel,
  output logic [7:0]        dis_seg
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int IDX_W = $clog2(DIGITS);
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low g..a patterns.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [DIGITS-1:0] sel_code(input logic [IDX_W-1:0] idx);
    logic [DIGITS-1:0] oh;
    oh = DIGITS'(1) << idx;
    return (SEL_ACTIVE_LOW != 0) ? ~oh : oh;
  endfunction

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;

  logic [BIN_W-1:0]  bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic              sticky_q;
  logic              neg_q;
  logic [DIGITS-1:0] dpc_q;
  logic              load_ovf;

  logic [BCD_W-1:0]  disp_bcd_q;
  logic              sign_q;
  logic [DIGITS-1:0] disp_dp_q;
  logic              ovf_q;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DIGITS-1:0] dis_sel_q;
  logic [7:0]        dis_seg_q;

  logic [DIGITS-1:0] blank;
  logic              clear;
  logic [IDX_W-1:0]  sign_pos;
  logic [3:0]        nib;
  logic              dp_on;
  logic [7:0]        seg_raw;

  assign bcd_adj  = add3(bcd_q);
  assign load_ovf = sticky_q | (neg_q & (bcd_q[BCD_W-1 -: 4] != 4'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (din_valid) begin
            state_q <= CONV;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        CONV: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BIN_W - 1)) state_q <= LOAD;
        end
        LOAD: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Conversion datapath; only meaningful while the FSM is in CONV/LOAD.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && din_valid) begin
      bin_q    <= din;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      neg_q    <= din_neg;
      dpc_q    <= dp_mask;
    end else if (state_q == CONV) begin
      bcd_q    <= {bcd_adj[BCD_W-2:0], bin_q[BIN_W-1]};
      bin_q    <= {bin_q[BIN_W-2:0], 1'b0};
      sticky_q <= sticky_q | bcd_adj[BCD_W-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      disp_bcd_q <= '0;
      sign_q     <= 1'b0;
      disp_dp_q  <= '0;
      ovf_q      <= 1'b0;
    end else if (state_q == LOAD) begin
      disp_bcd_q <= bcd_q;
      sign_q     <= neg_q && (bcd_q != '0);
      disp_dp_q  <= dpc_q;
      ovf_q      <= load_ovf;
    end
  end

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit blanks only when it and everything above it is zero with no dp.
  always_comb begin
    blank    = '0;
    clear    = 1'b1;
    sign_pos = IDX_W'(DIGITS - 1);
    for (int i = DIGITS - 1; i >= 0; i--) begin
      clear    = clear && (disp_bcd_q[4*i +: 4] == 4'd0) && !disp_dp_q[i];
      blank[i] = blank_en && (i > 0) && clear;
    end
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (blank[i]) sign_pos = IDX_W'(i);
    end
  end

  always_comb begin
    nib   = disp_bcd_q[int'(idx_d) * 4 +: 4];
    dp_on = disp_dp_q[idx_d] && !blank[idx_d];
    if (ovf_q)                          seg_raw = 8'hBF;
    else if (sign_q && idx_d == sign_pos) seg_raw = {!dp_on, 7'b0111111};
    else if (blank[idx_d])              seg_raw = 8'hFF;
    else                                seg_raw = {!dp_on, seg7(nib)};
  end

  // Select and segment data both come from idx_d so they switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      idx_q     <= '0;
      dis_sel_q <= sel_code('0);
      dis_seg_q <= (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      dis_sel_q <= sel_code(idx_d);
      dis_seg_q <= (SEG_ACTIVE_LOW != 0) ? seg_raw : ~seg_raw;
    end
  end

  assign busy    = busy_q;
  assign ovf     = ovf_q;
  assign dis_sel = dis_sel_q;
  assign dis_seg = dis_seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=6, BIN_W=20 and a short scan period.
module tb_seg_scan_ctrl;
  localparam int DIGITS = 6;
  localparam int BIN_W  = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [BIN_W-1:0]  din;
  logic              din_neg;
  logic [DIGITS-1:0] dp_mask;
  logic              din_valid;
  logic              blank_en;
  logic              busy;
  logic              ovf;
  logic [DIGITS-1:0] dis_sel;
  logic [7:0]        dis_seg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS(DIGITS), .BIN_W(BIN_W), .SCAN_DIV(4),
    .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .din(din), .din_neg(din_neg), .dp_mask(dp_mask),
    .din_valid(din_valid), .blank_en(blank_en), .busy(busy), .ovf(ovf),
    .dis_sel(dis_sel), .dis_seg(dis_seg)
  );

  function automatic logic [DIGITS-1:0] sel_of(input int d);
    logic [DIGITS-1:0] oh;
    oh = DIGITS'(1) << d;
    return ~oh;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_digit(input int d, input logic [7:0] exp, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (dis_sel !== sel_of(d) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (dis_sel !== sel_of(d)) chk({tag, "_seltimeout"}, 32'(dis_sel), 32'(sel_of(d)));
    else                       chk(tag, 32'(dis_seg), 32'(exp));
  endtask

  task automatic check_all(input logic [47:0] e, input string tag);
    for (int i = 0; i < DIGITS; i++)
      check_digit(i, e[8*i +: 8], $sformatf("%s_d%0d", tag, i));
  endtask

  task automatic load(input logic [BIN_W-1:0] v, input logic neg, input logic [DIGITS-1:0] dp);
    @(negedge clk);
    din       = v;
    din_neg   = neg;
    dp_mask   = dp;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    logic [47:0] e;
    logic [DIGITS-1:0] prev;

    rst = 1'b1; din = '0; din_neg = 1'b0; dp_mask = '0; din_valid = 1'b0; blank_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sel",  32'(dis_sel), 32'h3E);
    chk("rst_seg",  32'(dis_seg), 32'hFF);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ovf",  32'(ovf), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_sel0", 32'(dis_sel), 32'h3E);
    chk("idle_seg0", 32'(dis_seg), 32'hC0);
    check_all({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}, "idle");

    load(20'd12345, 1'b0, 6'b000000);
    chk("busy_start", 32'(busy), 32'h1);
    wait_idle(cyc);
    chk("busy_len", 32'(cyc), 32'd21);
    chk("ovf_12345", 32'(ovf), 32'h0);
    check_all({8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}, "v12345");

    load(20'd25, 1'b1, 6'b000010);
    wait_idle(cyc);
    chk("ovf_neg25", 32'(ovf), 32'h0);
    check_all({8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'h24, 8'h92}, "neg25dp");

    load(20'd999999, 1'b0, 6'b000000);
    wait_idle(cyc);
    chk("ovf_999999", 32'(ovf), 32'h0);
    check_all({8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}, "v999999");

    load(20'd1000000, 1'b0, 6'b000000);
    wait_idle(cyc);
    chk("ovf_1000000", 32'(ovf), 32'h1);
    check_all({8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF}, "v1000000");

    load(20'd100000, 1'b1, 6'b000000);
    wait_idle(cyc);
    chk("ovf_neg100000", 32'(ovf), 32'h1);
    check_digit(0, 8'hBF, "neg100000_d0");
    check_digit(5, 8'hBF, "neg100000_d5");

    load(20'd4321, 1'b0, 6'b000000);
    repeat (10) @(negedge clk);
    chk("busy_midconv", 32'(busy), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    repeat (30) @(negedge clk);
    chk("abort_busy_late", 32'(busy), 32'h0);
    chk("abort_ovf", 32'(ovf), 32'h0);
    check_all({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}, "abort");

    load(20'd777, 1'b0, 6'b000000);
    repeat (5) @(negedge clk);
    chk("busy_drop", 32'(busy), 32'h1);
    din = 20'd888; din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    wait_idle(cyc);
    @(negedge clk);
    chk("no_queue", 32'(busy), 32'h0);
    check_all({8'hFF, 8'hFF, 8'hFF, 8'hF8, 8'hF8, 8'hF8}, "drop");

    load(20'd0, 1'b1, 6'b000000);
    wait_idle(cyc);
    check_all({8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}, "negzero");

    blank_en = 1'b0;
    load(20'd25, 1'b1, 6'b000000);
    wait_idle(cyc);
    e = {8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'hA4, 8'h92};
    check_all(e, "noblank");

    n = 0;
    while (dis_sel !== sel_of(5) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("scan_reach5", 32'(dis_sel), 32'(sel_of(5)));
    prev = dis_sel;
    n = 0;
    while (dis_sel === prev && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("scan_wrap_sel", 32'(dis_sel), 32'(sel_of(0)));
    chk("scan_wrap_seg", 32'(dis_seg), 32'(e[7:0]));
    for (int k = 1; k <= DIGITS; k++) begin
      prev = dis_sel;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (dis_sel === prev && n < 10);
      chk($sformatf("scan_dwell%0d", k), 32'(n), 32'd4);
      chk($sformatf("scan_sel%0d", k), 32'(dis_sel), 32'(sel_of(k % DIGITS)));
      chk($sformatf("scan_seg%0d", k), 32'(dis_seg), 32'(e[8*(k % DIGITS) +: 8]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
